key_scan_enc: RTL and testbench

KEY_SCAN_ENC -- requirements
Module: key_scan_enc

---
 rtl/key_pkg.sv | 30 +++
 rtl/key_sync2.sv | 29 ++
 rtl/key_scan_enc.sv | 169 ++++++++++++++++
 tb/tb_key_scan_enc.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key scanner: FSM state enum, key count,
// released-vector constant and the single-key index decoder.
package key_pkg;

    localparam int NUM_KEYS = 6;
    localparam logic [NUM_KEYS-1:0] KEY_IDLE_VEC = 6'b111111;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        WAIT_RELEASE
    } key_state_t;

    // Keys are active-low: returns 1..NUM_KEYS for exactly one zero bit, else 0.
    function automatic logic [2:0] onehot0_index(input logic [NUM_KEYS-1:0] v);
        logic [2:0] idx;
        int         zeros;
        idx   = 3'd0;
        zeros = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!v[i]) begin
                zeros = zeros + 1;
                idx   = 3'(i + 1);
            end
        end
        return (zeros == 1) ? idx : 3'd0;
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for the raw push-button vector; resets to the
// released pattern so no phantom press is seen coming out of reset.
module key_sync2 #(
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_p0;
    logic [W-1:0] sync_p1;

    // Stage p0 may go metastable; p1 is the first value safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/key_scan_enc.sv
// Debounced 6-key encoder with valid/ready event handshake and overrun pulse.
// Define KEY_AUTOREPEAT_EN to add typematic repeat events while a key is held.
module key_scan_enc
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:1] key,
    output logic [2:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_overrun,
    output logic [6:1] key_stable
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic [6:1]       ks;
    key_state_t       state, state_nx;
    logic [6:1]       snap, snap_nx;
    logic [6:1]       stable_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       code_snap;
    logic [2:0]       ev_code;
    logic             emit;

    key_sync2 #(
        .W      (NUM_KEYS),
        .RST_VAL(KEY_IDLE_VEC)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (key),
        .q    (ks)
    );

    assign code_snap = onehot0_index(snap);

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nx;
    logic             rpt_first, rpt_first_nx;
`endif

    always_comb begin
        state_nx  = state;
        snap_nx   = snap;
        stable_nx = key_stable;
        cnt_nx    = '0;
        emit      = 1'b0;
        ev_code   = 3'd0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_nx   = '0;
        rpt_first_nx = 1'b1;
`endif
        case (state)
            IDLE: begin
                if (ks != KEY_IDLE_VEC) begin
                    snap_nx  = ks;
                    state_nx = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ks != snap) begin
                    snap_nx = ks;
                end else if (cnt == DEB_LAST) begin
                    stable_nx = snap;
                    if (snap == KEY_IDLE_VEC) begin
                        state_nx = IDLE;
                    end else if (code_snap != 3'd0) begin
                        emit     = 1'b1;
                        ev_code  = code_snap;
                        state_nx = HELD;
                    end else begin
                        state_nx = WAIT_RELEASE;
                    end
                end else begin
                    cnt_nx = sat_inc(cnt);
                end
            end
            HELD: begin
                // Any change, including release, is re-debounced; release itself is silent.
                if (ks != key_stable) begin
                    snap_nx  = ks;
                    state_nx = DEBOUNCE;
                end
`ifdef KEY_AUTOREPEAT_EN
                else begin
                    rpt_first_nx = rpt_first;
                    if (rpt_cnt == (rpt_first ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
                        emit         = 1'b1;
                        ev_code      = onehot0_index(key_stable);
                        rpt_first_nx = 1'b0;
                    end else begin
                        rpt_cnt_nx = sat_inc(rpt_cnt);
                    end
                end
`endif
            end
            WAIT_RELEASE: begin
                if (ks == KEY_IDLE_VEC) begin
                    snap_nx  = ks;
                    state_nx = DEBOUNCE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snap       <= KEY_IDLE_VEC;
            cnt        <= '0;
            key_stable <= KEY_IDLE_VEC;
        end else begin
            state      <= state_nx;
            snap       <= snap_nx;
            cnt        <= cnt_nx;
            key_stable <= stable_nx;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt_nx;
            rpt_first <= rpt_first_nx;
        end
    end
`endif

    // A pending, unaccepted event always wins; the newcomer is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid   <= 1'b0;
            key_code    <= 3'd0;
            key_overrun <= 1'b0;
        end else begin
            key_overrun <= 1'b0;
            if (emit && key_valid && !key_ready) begin
                key_overrun <= 1'b1;
            end else if (emit) begin
                key_valid <= 1'b1;
                key_code  <= ev_code;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
                key_code  <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_key_scan_enc.sv
// Bench for key_scan_enc: directed scenarios plus a random key stream, all
// checked against an event-level reference model of the debounce/handshake rules.
module tb_key_scan_enc;

    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RC  = 10;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:1] key = 6'b111111;
    logic       key_ready = 1'b1;
    logic [2:0] key_code;
    logic       key_valid;
    logic       key_overrun;
    logic [6:1] key_stable;

    int vectors = 0;
    int errors  = 0;

    key_scan_enc #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_overrun(key_overrun),
        .key_stable (key_stable)
    );

    always #5 clk = ~clk;

    // Reference model state: what the synchronized keys look like, how long the
    // current candidate vector has been steady, and the consumer-side event slot.
    logic [6:1] h0, h1, m_stable, run_val;
    bit         tracking, blocked, held, first;
    int         run_len, hcnt;
    logic       m_valid, m_ovr;
    logic [2:0] m_code;

    function automatic int zero_pos(input logic [6:1] v);
        for (int i = 1; i <= 6; i++) if (!v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        h0 = '1; h1 = '1; m_stable = '1; run_val = '1;
        tracking = 0; blocked = 0; held = 0; first = 0;
        run_len = 0; hcnt = 0;
        m_valid = 0; m_ovr = 0; m_code = 0;
    endtask

    task automatic model_step();
        logic [6:1] s;
        logic [2:0] code;
        bit         ev;
        int         zeros;
        if (!rst_n) return;
        s  = h1;
        h1 = h0;
        h0 = key;
        ev = 0;
        code = 0;
        if (blocked) begin
            if (s == 6'b111111) begin
                blocked = 0; tracking = 1; run_val = s; run_len = 1;
            end
        end else if (!tracking) begin
            if (s != m_stable) begin
                tracking = 1; run_val = s; run_len = 1; held = 0;
            end else if (held && AR) begin
                hcnt++;
                if (hcnt == (first ? RD : RC)) begin
                    ev = 1; code = 3'(zero_pos(m_stable)); hcnt = 0; first = 0;
                end
            end
        end else if (s != run_val) begin
            run_val = s; run_len = 1;
        end else if (run_len == DEB) begin
            // A new vector is accepted once it has been seen DEB+1 times in a row.
            m_stable = run_val; tracking = 0; held = 0;
            zeros = 6 - $countones(run_val);
            if (zeros == 1) begin
                ev = 1; code = 3'(zero_pos(run_val)); held = 1; hcnt = 0; first = 1;
            end else if (zeros > 1) begin
                blocked = 1;
            end
        end else begin
            run_len++;
        end
        m_ovr = 0;
        if (ev) begin
            if (m_valid && !key_ready) m_ovr = 1;
            else begin m_valid = 1; m_code = code; end
        end else if (m_valid && key_ready) begin
            m_valid = 0; m_code = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        key = 6'($urandom);
        key_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        vectors++; if (key_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
        vectors++; if (key_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", key_overrun); end
        vectors++; if (key_stable !== 6'b111111) begin errors++; $display("FAIL reset_stable: got %b want 111111", key_stable); end
        key = '1;
        rst_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            vectors++;
            if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                errors++;
                $display("FAIL reset_idle n=%0d: got v=%b c=%0d o=%b s=%b want v=%b c=%0d o=%b s=%b",
                         n, key_valid, key_code, key_overrun, key_stable, m_valid, m_code, m_ovr, m_stable);
            end
        end
    endtask

    task automatic test_single_press();
        int k, ev_cnt;
        k = $urandom_range(1, 6);
        ev_cnt = 0;
        key = '1;
        key[k] = 1'b0;
        for (int n = 1; n <= 35; n++) begin
            tick();
            vectors++;
            if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                errors++;
                $display("FAIL press_model n=%0d: got v=%b c=%0d o=%b s=%b want v=%b c=%0d o=%b s=%b",
                         n, key_valid, key_code, key_overrun, key_stable, m_valid, m_code, m_ovr, m_stable);
            end
            if (key_valid) ev_cnt++;
            if (n == DEB + 3) begin
                vectors++;
                if (key_valid !== 1'b1 || key_code !== 3'(k)) begin
                    errors++;
                    $display("FAIL press_latency: got v=%b c=%0d want v=1 c=%0d", key_valid, key_code, k);
                end
            end
        end
        vectors++;
        if (ev_cnt != (AR ? 2 : 1)) begin errors++; $display("FAIL press_count: got %0d want %0d", ev_cnt, AR ? 2 : 1); end
        key = '1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            vectors++;
            if (key_valid !== 1'b0 || key_stable !== m_stable) begin
                errors++;
                $display("FAIL release_silent n=%0d: got v=%b s=%b want v=0 s=%b", n, key_valid, key_stable, m_stable);
            end
        end
    endtask

    task automatic test_bounce();
        for (int n = 0; n < 60; n++) begin
            key = (n < 40 && ((n / 3) % 2) == 0) ? 6'b111110 : 6'b111111;
            tick();
            vectors++;
            if (key_valid !== 1'b0 || key_stable !== 6'b111111 || key_stable !== m_stable) begin
                errors++;
                $display("FAIL bounce n=%0d: got v=%b s=%b want v=0 s=111111", n, key_valid, key_stable);
            end
        end
    endtask

    task automatic test_multi_key();
        int ev6;
        ev6 = 0;
        key = 6'b101101;
        for (int n = 1; n <= 25; n++) begin
            tick();
            vectors++;
            if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_no_event n=%0d: got v=%b want 0", n, key_valid); end
        end
        vectors++;
        if (key_stable !== 6'b101101) begin errors++; $display("FAIL multi_stable: got %b want 101101", key_stable); end
        key = '1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 20) key = 6'b011111;
            tick();
        end
        for (int n = 1; n <= 25; n++) begin
            tick();
            vectors++;
            if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                errors++;
                $display("FAIL multi_model n=%0d: got v=%b c=%0d o=%b s=%b want v=%b c=%0d o=%b s=%b",
                         n, key_valid, key_code, key_overrun, key_stable, m_valid, m_code, m_ovr, m_stable);
            end
            if (key_valid && key_code == 3'd6) ev6++;
        end
        vectors++;
        if (ev6 != 1) begin errors++; $display("FAIL multi_key6: got %0d events want 1", ev6); end
        key = '1;
        repeat (20) tick();
    endtask

    task automatic test_overrun();
        int ovr;
        logic [6:1] seq [3];
        ovr = 0;
        seq[0] = 6'b111110; seq[1] = 6'b111111; seq[2] = 6'b111101;
        key_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            key = seq[p];
            for (int n = 1; n <= 15; n++) begin
                tick();
                vectors++;
                if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                    errors++;
                    $display("FAIL overrun_model p=%0d n=%0d: got v=%b c=%0d o=%b want v=%b c=%0d o=%b",
                             p, n, key_valid, key_code, key_overrun, m_valid, m_code, m_ovr);
                end
                if (key_overrun) ovr++;
            end
        end
        vectors++;
        if (ovr != 1) begin errors++; $display("FAIL overrun_count: got %0d want 1", ovr); end
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 3'd1) begin
            errors++; $display("FAIL overrun_keep: got v=%b c=%0d want v=1 c=1", key_valid, key_code);
        end
        key_ready = 1'b1;
        tick();
        vectors++;
        if (key_valid !== 1'b0 || key_code !== 3'd0) begin
            errors++; $display("FAIL overrun_accept: got v=%b c=%0d want v=0 c=0", key_valid, key_code);
        end
        key = '1;
        repeat (20) tick();
    endtask

    task automatic test_autorepeat();
        int times [$];
        key_ready = 1'b1;
        key = 6'b110111;
        for (int n = 1; n <= 70; n++) begin
            tick();
            vectors++;
            if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                errors++;
                $display("FAIL repeat_model n=%0d: got v=%b c=%0d o=%b want v=%b c=%0d o=%b",
                         n, key_valid, key_code, key_overrun, m_valid, m_code, m_ovr);
            end
            if (key_valid) begin
                times.push_back(n);
                vectors++;
                if (key_code !== 3'd4) begin errors++; $display("FAIL repeat_code n=%0d: got %0d want 4", n, key_code); end
            end
        end
        vectors++;
        if (times.size() != (AR ? 5 : 1)) begin
            errors++; $display("FAIL repeat_count: got %0d want %0d", times.size(), AR ? 5 : 1);
        end
        for (int i = 1; i < times.size(); i++) begin
            vectors++;
            if (times[i] - times[0] != RD + RC * (i - 1)) begin
                errors++; $display("FAIL repeat_offset i=%0d: got %0d want %0d", i, times[i] - times[0], RD + RC * (i - 1));
            end
        end
        key = '1;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid(input logic [6:1] vec, input int code, input bit pend);
        int evs, t_first;
        key_ready = !pend;
        key = vec;
        repeat (pend ? 14 : 6) tick();
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        vectors++;
        if ({key_valid, key_code, key_overrun, key_stable} !== {1'b0, 3'd0, 1'b0, 6'b111111}) begin
            errors++;
            $display("FAIL midreset_vals: got v=%b c=%0d o=%b s=%b want v=0 c=0 o=0 s=111111",
                     key_valid, key_code, key_overrun, key_stable);
        end
        key_ready = 1'b1;
        rst_n = 1'b1;
        evs = 0;
        t_first = 0;
        for (int n = 1; n <= 25; n++) begin
            tick();
            vectors++;
            if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                errors++;
                $display("FAIL midreset_model n=%0d: got v=%b c=%0d o=%b want v=%b c=%0d o=%b",
                         n, key_valid, key_code, key_overrun, m_valid, m_code, m_ovr);
            end
            if (key_valid && key_code == 3'(code)) begin
                evs++;
                if (t_first == 0) t_first = n;
            end
        end
        vectors++;
        if (evs != 1 || t_first != DEB + 3) begin
            errors++; $display("FAIL midreset_once: got %0d events at %0d want 1 at %0d", evs, t_first, DEB + 3);
        end
        key = '1;
        repeat (20) tick();
    endtask

    task automatic test_random();
        logic [6:1] vec;
        int dur, a;
        for (int seg = 0; seg < 40; seg++) begin
            vec = '1;
            case ($urandom_range(0, 3))
                0: vec = '1;
                1: begin a = $urandom_range(1, 6); vec[a] = 1'b0; end
                2: begin a = $urandom_range(1, 6); vec[a] = 1'b0; vec[(a % 6) + 1] = 1'b0; end
                default: vec = 6'($urandom);
            endcase
            dur = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 35);
            key = vec;
            for (int n = 0; n < dur; n++) begin
                key_ready = ($urandom_range(0, 3) != 0);
                tick();
                vectors++;
                if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                    errors++;
                    $display("FAIL random seg=%0d n=%0d: got v=%b c=%0d o=%b s=%b want v=%b c=%0d o=%b s=%b",
                             seg, n, key_valid, key_code, key_overrun, key_stable, m_valid, m_code, m_ovr, m_stable);
                end
            end
        end
        key = '1;
        key_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick();
            vectors++;
            if ({key_valid, key_code, key_overrun, key_stable} !== {m_valid, m_code, m_ovr, m_stable}) begin
                errors++;
                $display("FAIL random_settle n=%0d: got v=%b c=%0d s=%b want v=%b c=%0d s=%b",
                         n, key_valid, key_code, key_stable, m_valid, m_code, m_stable);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_autorepeat();
        test_reset_mid(6'b101111, 5, 1'b0);
        test_reset_mid(6'b111011, 3, 1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
